// File: rtl/sc1602_rx_if.sv
// SC1602 LCD pin bundle: DB7..DB4, RS and E.
// master drives the pins, slave observes them.
interface sc1602_rx_if;
  logic [3:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_enable;

  modport master (
    output lcd_data,
    output lcd_rs,
    output lcd_enable
  );

  modport slave (
    input lcd_data,
    input lcd_rs,
    input lcd_enable
  );
endinterface

// File: rtl/sc1602_rx.sv
// SC1602 (HD44780) receiver: decodes the nibble stream
// into a 2x16 char buffer plus display-control state.
//
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   lcd (slave)        : lcd_data, lcd_rs, lcd_enable pins
//   rd_addr / rd_char  : buffer read, 1-cycle latency
//   byte_valid/_data/_rs : completed byte pulse and value
//   cursor             : DDRAM address counter
//   disp_on/cursor_on/blink_on : D, C, B bits
//   mode_4bit, busy, err_busy  : interface/busy state
// Optional: SC1602_RX_BUSY_CHECK_EN adds the busy timer
// and the sticky err_busy flag.
module sc1602_rx #(
  parameter int CLEAR_CYCLES = 41000,
  parameter int CMD_CYCLES   = 1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  sc1602_rx_if.slave        lcd,
  input  logic [4:0]        rd_addr,
  output logic [7:0]        rd_char,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_rs,
  output logic [6:0]        cursor,
  output logic              disp_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              mode_4bit,
  output logic              busy,
  output logic              err_busy
);

  logic [3:0] data_s1;
  logic [3:0] data_s2;
  logic [3:0] data_d;
  logic       rs_s1;
  logic       rs_s2;
  logic       rs_d;
  logic       en_s1;
  logic       en_s2;
  logic       en_d;
  logic       fall_q;
  logic [3:0] nib_q;
  logic       rs_q;

  logic       phase_lo;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       inc;
  logic       sweep_on;
  logic [4:0] sweep_idx;

  logic       strobe;
  logic       byte_done;
  logic [7:0] cur_byte;
  logic       cur_rs;
  logic [7:0] hb;
  logic       seen;
  logic [6:0] step;

  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_val;
  logic [7:0] mem [32];

  // data_d/rs_d are the samples paired with en_d, so on a
  // fall they hold the value seen with the last high E.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_s1 <= '0;
      data_s2 <= '0;
      data_d  <= '0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rs_d    <= 1'b0;
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_d    <= 1'b0;
      fall_q  <= 1'b0;
      nib_q   <= '0;
      rs_q    <= 1'b0;
    end else begin
      data_s1 <= lcd.lcd_data;
      data_s2 <= data_s1;
      data_d  <= data_s2;
      rs_s1   <= lcd.lcd_rs;
      rs_s2   <= rs_s1;
      rs_d    <= rs_s2;
      en_s1   <= lcd.lcd_enable;
      en_s2   <= en_s1;
      en_d    <= en_s2;
      fall_q  <= en_d & ~en_s2;
      nib_q   <= data_d;
      rs_q    <= rs_d;
    end
  end

  // Strobes landing in a clear sweep are dropped whole.
  assign strobe = fall_q & ~sweep_on;

  always_comb begin
    byte_done = 1'b0;
    cur_byte  = {nib_q, 4'h0};
    cur_rs    = rs_q;
    if (strobe) begin
      if (!mode_4bit) begin
        byte_done = 1'b1;
      end else if (phase_lo) begin
        byte_done = 1'b1;
        cur_byte  = {hi_nib, nib_q};
        cur_rs    = hi_rs;
      end
    end
  end

  // One-hot of the highest set bit selects the command.
  always_comb begin
    hb   = '0;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      hb[i] = cur_byte[i] & ~seen;
      seen  = seen | cur_byte[i];
    end
  end

  // DDRAM addressing: line 1 is 0x00-0x27, line 2 is
  // 0x40-0x67; stepping wraps between the two lines.
  always_comb begin
    step = cursor + 7'd1;
    if (inc) begin
      if (cursor == 7'h27) begin
        step = 7'h40;
      end else if (cursor == 7'h67) begin
        step = 7'h00;
      end
    end else begin
      step = cursor - 7'd1;
      if (cursor == 7'h40) begin
        step = 7'h27;
      end else if (cursor == 7'h00) begin
        step = 7'h67;
      end
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sweep_idx;
    wr_val = 8'h20;
    if (sweep_on) begin
      wr_en = 1'b1;
    end else if (byte_done && cur_rs) begin
      if (cursor[6:4] == 3'b000) begin
        wr_en  = 1'b1;
        wr_idx = {1'b0, cursor[3:0]};
        wr_val = cur_byte;
      end else if (cursor[6:4] == 3'b100) begin
        wr_en  = 1'b1;
        wr_idx = {1'b1, cursor[3:0]};
        wr_val = cur_byte;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_val;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_char <= '0;
    end else begin
      rd_char <= mem[rd_addr];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_rs    <= 1'b0;
      cursor     <= '0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      mode_4bit  <= 1'b0;
      inc        <= 1'b1;
      phase_lo   <= 1'b0;
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      sweep_on   <= 1'b1;
      sweep_idx  <= '0;
    end else begin
      byte_valid <= byte_done;
      if (sweep_on) begin
        sweep_idx <= sweep_idx + 5'd1;
        if (sweep_idx == 5'd31) begin
          sweep_on <= 1'b0;
        end
      end
      if (strobe && mode_4bit) begin
        if (!phase_lo) begin
          hi_nib   <= nib_q;
          hi_rs    <= rs_q;
          phase_lo <= 1'b1;
        end else begin
          phase_lo <= 1'b0;
        end
      end
      if (byte_done) begin
        byte_data <= cur_byte;
        byte_rs   <= cur_rs;
        if (cur_rs) begin
          cursor <= step;
        end else begin
          unique case (1'b1)
            hb[7]: cursor <= cur_byte[6:0];
            hb[6], hb[4]: begin
            end
            hb[5]: begin
              if (!cur_byte[4]) begin
                mode_4bit <= 1'b1;
                phase_lo  <= 1'b0;
              end else begin
                mode_4bit <= 1'b0;
              end
            end
            hb[3]: begin
              disp_on   <= cur_byte[2];
              cursor_on <= cur_byte[1];
              blink_on  <= cur_byte[0];
            end
            hb[2]: inc <= cur_byte[1];
            hb[1]: cursor <= '0;
            hb[0]: begin
              cursor    <= '0;
              inc       <= 1'b1;
              sweep_on  <= 1'b1;
              sweep_idx <= '0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

`ifdef SC1602_RX_BUSY_CHECK_EN
  logic        is_long;
  logic [31:0] cnt;

  assign is_long = ~cur_rs & (hb[0] | hb[1]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      err_busy <= 1'b0;
    end else begin
      if (byte_done) begin
        cnt <= is_long ? 32'(CLEAR_CYCLES)
                       : 32'(CMD_CYCLES);
      end else if (cnt != 32'd0) begin
        cnt <= cnt - 32'd1;
      end
      if (strobe && cnt != 32'd0) begin
        err_busy <= 1'b1;
      end
    end
  end

  assign busy = sweep_on | (cnt != 32'd0);
`else
  logic unused_cfg;

  assign unused_cfg = ^{CLEAR_CYCLES, CMD_CYCLES};
  assign busy       = sweep_on;
  assign err_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_sc1602_rx.sv
// Self-checking bench for sc1602_rx: drives nibble
// strobes and compares against a behavioural LCD model.
module tb_sc1602_rx;

`ifdef SC1602_RX_BUSY_CHECK_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic [6:0] cursor;
  logic       disp_on;
  logic       cursor_on;
  logic       blink_on;
  logic       mode_4bit;
  logic       busy;
  logic       err_busy;

  always #5 clk = ~clk;

  sc1602_rx_if lcd ();

  sc1602_rx #(
    .CLEAR_CYCLES(300),
    .CMD_CYCLES  (100)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .lcd       (lcd.slave),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_rs   (byte_rs),
    .cursor    (cursor),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .mode_4bit (mode_4bit),
    .busy      (busy),
    .err_busy  (err_busy)
  );

  int checks = 0;
  int failures = 0;

  int         bv_cnt = 0;
  logic [8:0] bv_last = '0;
  logic [8:0] bvq[$];

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      bv_last = {byte_rs, byte_data};
      bvq.push_back({byte_rs, byte_data});
    end
  end

  // Behavioural display model
  int         m_cur;
  bit         m_id;
  bit         m_mode4;
  bit         m_lo;
  logic [3:0] m_hin;
  bit         m_hrs;
  bit         m_d, m_c, m_b;
  logic [7:0] m_buf[32];
  int         exp_cnt = 0;
  logic [8:0] exp_last = '0;

  task automatic model_reset();
    m_cur = 0;
    m_id = 1;
    m_mode4 = 0;
    m_lo = 0;
    m_d = 0;
    m_c = 0;
    m_b = 0;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
  endtask

  task automatic model_byte(input logic [7:0] b,
                            input bit rs);
    exp_cnt++;
    exp_last = {rs, b};
    if (rs) begin
      if (m_cur < 16) m_buf[m_cur] = b;
      else if (m_cur >= 64 && m_cur < 80)
        m_buf[m_cur - 48] = b;
      if (m_id) begin
        if (m_cur == 39) m_cur = 64;
        else if (m_cur == 103) m_cur = 0;
        else m_cur = (m_cur + 1) % 128;
      end else begin
        if (m_cur == 64) m_cur = 39;
        else if (m_cur == 0) m_cur = 103;
        else m_cur = (m_cur + 127) % 128;
      end
    end else if (b >= 128) begin
      m_cur = int'(b) - 128;
    end else if (b >= 64) begin
    end else if (b >= 32) begin
      if (b[4] == 1'b0) begin
        m_mode4 = 1;
        m_lo = 0;
      end else begin
        m_mode4 = 0;
      end
    end else if (b >= 16) begin
    end else if (b >= 8) begin
      m_d = b[2];
      m_c = b[1];
      m_b = b[0];
    end else if (b >= 4) begin
      m_id = b[1];
    end else if (b >= 2) begin
      m_cur = 0;
    end else if (b == 1) begin
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
      m_cur = 0;
      m_id = 1;
    end
  endtask

  task automatic model_nib(input logic [3:0] n,
                           input bit rs);
    if (!m_mode4) begin
      model_byte({n, 4'h0}, rs);
    end else if (!m_lo) begin
      m_hin = n;
      m_hrs = rs;
      m_lo = 1;
    end else begin
      m_lo = 0;
      model_byte({m_hin, n}, m_hrs);
    end
  endtask

  task automatic send_nib(input logic [3:0] n,
                          input bit rs,
                          input bit drop);
    @(negedge clk);
    lcd.lcd_data = n;
    lcd.lcd_rs = rs;
    lcd.lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    lcd.lcd_enable = 1'b0;
    repeat (6) @(negedge clk);
    if (!drop) model_nib(n, rs);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit rs);
    if (m_mode4) begin
      send_nib(b[7:4], rs, 1'b0);
      send_nib(b[3:0], rs, 1'b0);
    end else begin
      send_nib(b[7:4], rs, 1'b0);
    end
    if (!rs && b == 8'h01) repeat (36) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lcd.lcd_data = '0;
    lcd.lcd_rs = 1'b0;
    lcd.lcd_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    lcd.lcd_data = '0;
    lcd.lcd_rs = 1'b0;
    lcd.lcd_enable = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, byte_valid, err_busy, mode_4bit}
        !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1000",
               {busy, byte_valid, err_busy, mode_4bit});
    end
    checks++;
    if ({rd_char, byte_data, cursor} !== 23'd0) begin
      failures++;
      $display("FAIL reset_regs got=%h/%h/%h exp=0",
               rd_char, byte_data, cursor);
    end
    rst_n = 1'b1;
    repeat (31) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_c31 got=%b exp=1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_c32 got=%b exp=0", busy);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      checks++;
      if (rd_char !== m_buf[i]) begin
        failures++;
        $display("FAIL rst_buf[%0d] got=%h exp=%h",
                 i, rd_char, m_buf[i]);
      end
    end
    checks++;
    if (bv_cnt !== 0) begin
      failures++;
      $display("FAIL rst_bv got=%0d exp=0", bv_cnt);
    end
  endtask

  task automatic test_init();
    logic [8:0] ie[5];
    ie = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h028};
    bvq.delete();
    send_nib(4'h3, 1'b0, 1'b0);
    send_nib(4'h3, 1'b0, 1'b0);
    send_nib(4'h3, 1'b0, 1'b0);
    checks++;
    if (mode_4bit !== 1'b0) begin
      failures++;
      $display("FAIL init_mode3 got=%b exp=0", mode_4bit);
    end
    send_nib(4'h2, 1'b0, 1'b0);
    checks++;
    if (mode_4bit !== 1'b1) begin
      failures++;
      $display("FAIL init_mode4 got=%b exp=1", mode_4bit);
    end
    send_nib(4'h2, 1'b0, 1'b0);
    checks++;
    if (bvq.size() !== 4) begin
      failures++;
      $display("FAIL init_hi_nib got=%0d exp=4",
               bvq.size());
    end
    send_nib(4'h8, 1'b0, 1'b0);
    checks++;
    if (bvq.size() !== 5) begin
      failures++;
      $display("FAIL init_count got=%0d exp=5",
               bvq.size());
    end
    for (int i = 0; i < 5 && i < bvq.size(); i++) begin
      checks++;
      if (bvq[i] !== ie[i]) begin
        failures++;
        $display("FAIL init_byte[%0d] got=%h exp=%h",
                 i, bvq[i], ie[i]);
      end
    end
    checks++;
    if (mode_4bit !== 1'(m_mode4)) begin
      failures++;
      $display("FAIL init_mode_end got=%b exp=%b",
               mode_4bit, m_mode4);
    end
  endtask

  task automatic test_latency();
    int n;
    send_nib(4'h0, 1'b0, 1'b0);
    @(negedge clk);
    lcd.lcd_data = 4'hC;
    lcd.lcd_rs = 1'b0;
    lcd.lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    lcd.lcd_enable = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!byte_valid && n < 20);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL bv_latency got=%0d exp=4", n);
    end
    @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0) begin
      failures++;
      $display("FAIL bv_width got=%b exp=0", byte_valid);
    end
    repeat (4) @(negedge clk);
    model_nib(4'hC, 1'b0);
    checks++;
    if ({disp_on, cursor_on, blink_on} !== {m_d, m_c, m_b})
    begin
      failures++;
      $display("FAIL lat_dcb got=%b exp=%b",
               {disp_on, cursor_on, blink_on},
               {m_d, m_c, m_b});
    end
  endtask

  task automatic test_display();
    send_byte(8'h0E, 1'b0);
    send_byte(8'h41, 1'b1);
    checks++;
    if ({disp_on, cursor_on, blink_on} !== 3'b110) begin
      failures++;
      $display("FAIL disp_dcb got=%b exp=110",
               {disp_on, cursor_on, blink_on});
    end
    checks++;
    if (cursor !== 7'h01) begin
      failures++;
      $display("FAIL disp_cursor got=%h exp=01", cursor);
    end
    checks++;
    if ({byte_rs, byte_data} !== 9'h141) begin
      failures++;
      $display("FAIL disp_byte got=%h exp=141",
               {byte_rs, byte_data});
    end
    rd_addr = 5'd0;
    @(negedge clk);
    checks++;
    if (rd_char !== 8'h41) begin
      failures++;
      $display("FAIL disp_idx0 got=%h exp=41", rd_char);
    end
  endtask

  task automatic test_line2();
    send_byte(8'hC0, 1'b0);
    send_byte(8'h42, 1'b1);
    rd_addr = 5'd16;
    @(negedge clk);
    checks++;
    if (rd_char !== 8'h42) begin
      failures++;
      $display("FAIL line2_idx16 got=%h exp=42", rd_char);
    end
    send_byte(8'hA7, 1'b0);
    send_byte(8'h43, 1'b1);
    checks++;
    if (cursor !== 7'h40) begin
      failures++;
      $display("FAIL wrap_cursor got=%h exp=40", cursor);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      checks++;
      if (rd_char !== m_buf[i]) begin
        failures++;
        $display("FAIL line2_buf[%0d] got=%h exp=%h",
                 i, rd_char, m_buf[i]);
      end
    end
  endtask

  task automatic test_clear();
    int c0;
    send_nib(4'h0, 1'b0, 1'b0);
    send_nib(4'h1, 1'b0, 1'b0);
    c0 = bv_cnt;
    send_nib(4'h5, 1'b1, 1'b1);
    send_nib(4'h8, 1'b1, 1'b1);
    checks++;
    if (bv_cnt !== c0) begin
      failures++;
      $display("FAIL sweep_drop got=%0d exp=%0d",
               bv_cnt, c0);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (cursor !== 7'h00) begin
      failures++;
      $display("FAIL clr_cursor got=%h exp=00", cursor);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      checks++;
      if (rd_char !== m_buf[i]) begin
        failures++;
        $display("FAIL clr_buf[%0d] got=%h exp=%h",
                 i, rd_char, m_buf[i]);
      end
    end
    send_byte(8'h61, 1'b1);
    rd_addr = 5'd0;
    @(negedge clk);
    checks++;
    if (rd_char !== 8'h61) begin
      failures++;
      $display("FAIL clr_after got=%h exp=61", rd_char);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         rs;
    int         op;
    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 10));
      rs = 1'b0;
      if (op <= 4) begin
        b = 8'($urandom_range(32, 126));
        rs = 1'b1;
      end else if (op <= 6) begin
        case ($urandom_range(0, 4))
          0: b = 8'h80 | 8'($urandom_range(0, 15));
          1: b = 8'hC0 | 8'($urandom_range(0, 15));
          2: b = ($urandom_range(0, 1) != 0) ? 8'hA7
                                              : 8'hE7;
          3: b = ($urandom_range(0, 1) != 0) ? 8'h80
                                              : 8'hC0;
          default: b = 8'h80 | 8'($urandom_range(0, 127));
        endcase
      end else if (op == 7) begin
        b = 8'h04 | 8'($urandom_range(0, 3));
      end else if (op == 8) begin
        b = 8'h08 | 8'($urandom_range(0, 7));
      end else if (op == 9) begin
        b = 8'h02 | 8'($urandom_range(0, 1));
      end else begin
        case ($urandom_range(0, 2))
          0: b = 8'h10 | 8'($urandom_range(0, 15));
          1: b = 8'h40 | 8'($urandom_range(0, 63));
          default: b = 8'h28;
        endcase
      end
      send_byte(b, rs);
      checks++;
      if (cursor !== 7'(m_cur)) begin
        failures++;
        $display("FAIL rnd_cursor k=%0d b=%h got=%h exp=%h",
                 k, b, cursor, 7'(m_cur));
      end
      checks++;
      if (bv_cnt !== exp_cnt ||
          {byte_rs, byte_data} !== exp_last) begin
        failures++;
        $display("FAIL rnd_byte k=%0d got=%0d/%h exp=%0d/%h",
                 k, bv_cnt, {byte_rs, byte_data},
                 exp_cnt, exp_last);
      end
    end
    checks++;
    if ({disp_on, cursor_on, blink_on, mode_4bit} !==
        {m_d, m_c, m_b, m_mode4}) begin
      failures++;
      $display("FAIL rnd_ctrl got=%b exp=%b",
               {disp_on, cursor_on, blink_on, mode_4bit},
               {m_d, m_c, m_b, m_mode4});
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      checks++;
      if (rd_char !== m_buf[i]) begin
        failures++;
        $display("FAIL rnd_buf[%0d] got=%h exp=%h",
                 i, rd_char, m_buf[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h80, 1'b0);
    send_byte(8'h5A, 1'b1);
    send_nib(4'h4, 1'b1, 1'b0);
    do_reset();
    checks++;
    if ({mode_4bit, cursor} !== 8'h00) begin
      failures++;
      $display("FAIL mid_state got=%b/%h exp=0/00",
               mode_4bit, cursor);
    end
    rd_addr = 5'd0;
    @(negedge clk);
    checks++;
    if (rd_char !== m_buf[0]) begin
      failures++;
      $display("FAIL mid_idx0 got=%h exp=%h",
               rd_char, m_buf[0]);
    end
    send_nib(4'h3, 1'b0, 1'b0);
    checks++;
    if (bv_cnt !== exp_cnt ||
        {byte_rs, byte_data} !== exp_last) begin
      failures++;
      $display("FAIL mid_byte got=%0d/%h exp=%0d/%h",
               bv_cnt, {byte_rs, byte_data},
               exp_cnt, exp_last);
    end
  endtask

  task automatic test_busy();
    do_reset();
    send_nib(4'h3, 1'b0, 1'b0);
    checks++;
    if ({busy, err_busy} !== {BUSY_EN, 1'b0}) begin
      failures++;
      $display("FAIL busy_first got=%b exp=%b",
               {busy, err_busy}, {BUSY_EN, 1'b0});
    end
    repeat (36) @(negedge clk);
    checks++;
    if (busy !== BUSY_EN) begin
      failures++;
      $display("FAIL busy_hold got=%b exp=%b",
               busy, BUSY_EN);
    end
    send_nib(4'h3, 1'b0, 1'b0);
    checks++;
    if ({busy, err_busy} !== {BUSY_EN, BUSY_EN}) begin
      failures++;
      $display("FAIL busy_second got=%b exp=%b",
               {busy, err_busy}, {BUSY_EN, BUSY_EN});
    end
    repeat (110) @(negedge clk);
    checks++;
    if ({busy, err_busy} !== {1'b0, BUSY_EN}) begin
      failures++;
      $display("FAIL busy_sticky got=%b exp=%b",
               {busy, err_busy}, {1'b0, BUSY_EN});
    end
    checks++;
    if (bv_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL busy_bv got=%0d exp=%0d",
               bv_cnt, exp_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_latency();
    test_display();
    test_line2();
    test_clear();
    test_random();
    test_reset_mid();
    test_busy();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
